// File: rtl/en_evt_pkg.sv
// Shared types and default sizing for the debounced enable event counter.
package en_evt_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_CNT_W           = 8;
  localparam int unsigned RUN_W               = 4;

  typedef enum logic [1:0] {
    LOW,
    CONF_HI,
    HIGH,
    CONF_LO
  } evt_state_t;

endpackage

// File: rtl/en_sync.sv
// Two-flop synchronizer for a single asynchronous level, synchronous reset to 0.
module en_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/en_event_counter.sv
// Debounces the combined enable level and counts accepted rising edges.
// Define EN_EVT_SATURATE_EN to make evt_count hold at all-ones on overflow instead of wrapping.
module en_event_counter
  import en_evt_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_in,
  input  logic             clr,
  output logic             level,
  output logic             evt_pulse,
  output logic [CNT_W-1:0] evt_count,
  output logic             ovf
);

  localparam logic [RUN_W-1:0] DebTarget = RUN_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

  logic             en_s;
  evt_state_t       state_q;
  logic [RUN_W-1:0] run_q;
  logic             level_q;
  logic             pulse_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             enter_high;
  logic             enter_low;

  en_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (en_in),
    .q   (en_s)
  );

  // Confirmation completes on the sample that brings the run to DEBOUNCE_CYCLES.
  always_comb begin
    enter_high = 1'b0;
    enter_low  = 1'b0;
    case (state_q)
      LOW:     enter_high = en_s && (DebTarget == RUN_W'(1));
      CONF_HI: enter_high = en_s && ((run_q + RUN_W'(1)) == DebTarget);
      HIGH:    enter_low  = !en_s && (DebTarget == RUN_W'(1));
      CONF_LO: enter_low  = !en_s && ((run_q + RUN_W'(1)) == DebTarget);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOW;
      run_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= enter_high;
      case (state_q)
        LOW: begin
          if (enter_high) begin
            state_q <= HIGH;
            level_q <= 1'b1;
            run_q   <= '0;
          end else if (en_s) begin
            state_q <= CONF_HI;
            run_q   <= RUN_W'(1);
          end
        end
        CONF_HI: begin
          if (!en_s) begin
            state_q <= LOW;
            run_q   <= '0;
          end else if (enter_high) begin
            state_q <= HIGH;
            level_q <= 1'b1;
            run_q   <= '0;
          end else begin
            run_q <= run_q + RUN_W'(1);
          end
        end
        HIGH: begin
          if (enter_low) begin
            state_q <= LOW;
            level_q <= 1'b0;
            run_q   <= '0;
          end else if (!en_s) begin
            state_q <= CONF_LO;
            run_q   <= RUN_W'(1);
          end
        end
        CONF_LO: begin
          // Returning high from CONF_LO is not a new edge: no pulse, level already 1.
          if (en_s) begin
            state_q <= HIGH;
            run_q   <= '0;
          end else if (enter_low) begin
            state_q <= LOW;
            level_q <= 1'b0;
            run_q   <= '0;
          end else begin
            run_q <= run_q + RUN_W'(1);
          end
        end
        default: begin
          state_q <= LOW;
          run_q   <= '0;
        end
      endcase
    end
  end

  // clr wins over a same-cycle increment; it never touches the debounce FSM.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (enter_high) begin
      if (count_q == CntMax) begin
        ovf_q <= 1'b1;
`ifdef EN_EVT_SATURATE_EN
        count_q <= CntMax;
`else
        count_q <= '0;
`endif
      end else begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign level     = level_q;
  assign evt_pulse = pulse_q;
  assign evt_count = count_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_en_event_counter.sv
// Directed vector-table bench for en_event_counter (DEBOUNCE_CYCLES=4, CNT_W=8).
module tb_en_event_counter;

  localparam int D = 4;
  localparam int W = 8;

`ifdef EN_EVT_SATURATE_EN
  localparam logic [W-1:0] CntAt256 = 8'd255;
  localparam logic [W-1:0] CntAt257 = 8'd255;
`else
  localparam logic [W-1:0] CntAt256 = 8'd0;
  localparam logic [W-1:0] CntAt257 = 8'd1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         en_in;
  logic         clr;
  logic         level;
  logic         evt_pulse;
  logic [W-1:0] evt_count;
  logic         ovf;

  always #5 clk = ~clk;

  en_event_counter #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_in     (en_in),
    .clr       (clr),
    .level     (level),
    .evt_pulse (evt_pulse),
    .evt_count (evt_count),
    .ovf       (ovf)
  );

  typedef struct {
    logic         rst;
    logic         en;
    logic         clr;
    logic         lvl;
    logic         pls;
    logic [W-1:0] cnt;
    logic         ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic add(input logic r, input logic e, input logic c, input logic l,
                     input logic p, input logic [W-1:0] n, input logic o);
    vec_t v;
    v.rst = r; v.en = e; v.clr = c; v.lvl = l; v.pls = p; v.cnt = n; v.ovf = o;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int k, input logic r, input logic e, input logic c,
                       input logic l, input logic p, input logic [W-1:0] n, input logic o);
    for (int i = 0; i < k; i++) add(r, e, c, l, p, n, o);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, want %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int idx, input logic l, input logic p,
                           input logic [W-1:0] n, input logic o);
    check({name, ".level"}, idx, 32'(level), 32'(l));
    check({name, ".pulse"}, idx, 32'(evt_pulse), 32'(p));
    check({name, ".count"}, idx, 32'(evt_count), 32'(n));
    check({name, ".ovf"}, idx, 32'(ovf), 32'(o));
  endtask

  // Inputs change 1 ns after the edge; outputs are sampled at the same point.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic gen_event;
    en_in = 1'b1;
    repeat (8) tick();
    en_in = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    rst = 1'b1; en_in = 1'b0; clr = 1'b0;

    // rst overrides clr; outputs all zero
    add(1, 0, 1, 0, 0, 0, 0);
    // rising edge held: pulse after 6th edge, one cycle only
    add_n(5, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 1, 1, 0);
    add_n(2, 0, 1, 0, 1, 0, 1, 0);
    // falling edge: level drops after 6 edges, no pulse
    add_n(5, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0);
    // 3-cycle glitch: rejected
    add_n(3, 0, 1, 0, 0, 0, 1, 0);
    add_n(7, 0, 0, 0, 0, 0, 1, 0);
    // plain clr
    add(0, 0, 1, 0, 0, 0, 0);
    // clr coincides with the pulse edge: pulse still fires, count stays 0
    add_n(5, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 1, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0);
    add_n(5, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; en_in = vecs[i].en; clr = vecs[i].clr;
      tick();
      check_all("vec", i, vecs[i].lvl, vecs[i].pls, vecs[i].cnt, vecs[i].ovf);
    end
    rst = 1'b0; en_in = 1'b0; clr = 1'b0;

    // Overflow sequence from count 0
    for (int i = 0; i < 255; i++) gen_event();
    check_all("pre_ovf", 255, 1'b0, 1'b0, 8'd255, 1'b0);
    gen_event();
    check_all("ovf", 256, 1'b0, 1'b0, CntAt256, 1'b1);
    gen_event();
    check_all("ovf_sticky", 257, 1'b0, 1'b0, CntAt257, 1'b1);

    // Reset mid-confirmation (CONF_HI) with en_in held high
    en_in = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check_all("rst_conf", 0, 1'b0, 1'b0, 8'd0, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("post_rst.pulse", k, 32'(evt_pulse), 32'(k == 6));
    end
    check_all("post_rst", 6, 1'b1, 1'b1, 8'd1, 1'b0);
    tick();
    check_all("post_rst", 7, 1'b1, 1'b0, 8'd1, 1'b0);

    // clr after overflow-free state still leaves level alone
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_all("clr_high", 0, 1'b1, 1'b0, 8'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
